// File: rtl/dir_pad_pkg.sv
// Shared types for the direction pad: direction indices and strobe FSM states.
// Direction index order doubles as priority order (lowest index wins).
package dir_pad_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_RIGHT = 3'd0;
  localparam dir_t DIR_LEFT  = 3'd1;
  localparam dir_t DIR_UP    = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_NONE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    oh = 4'b0000;
    if (!d[2]) oh[d[1:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer followed by a counter debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  assign s = sync_q[1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/dir_pad_ctrl.sv
// Direction pad front end: four debounced buttons, fixed priority select and a
// press/auto-repeat FSM producing registered one-cycle direction strobes.
module dir_pad_ctrl
  import dir_pad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held
);

  // Timer runs from the load value down to zero and fires on the following
  // edge, so consecutive strobes land load+1 cycles apart.
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);

  logic [3:0]       raw;
  logic [3:0]       stb;
  dir_t             active;
  state_e           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [3:0]       strb_q, strb_d;

  assign raw = {btn_down, btn_up, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (raw[i]),
      .stable_o (stb[i])
    );
  end

  always_comb begin
    active = DIR_NONE;
    if (stb[DIR_DOWN[1:0]])  active = DIR_DOWN;
    if (stb[DIR_UP[1:0]])    active = DIR_UP;
    if (stb[DIR_LEFT[1:0]])  active = DIR_LEFT;
    if (stb[DIR_RIGHT[1:0]]) active = DIR_RIGHT;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    strb_d  = 4'b0000;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (active != DIR_NONE) begin
            strb_d  = dir_onehot(active);
            dir_d   = active;
            tmr_d   = DELAY_LOAD;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (active == DIR_NONE) begin
            state_d = ST_IDLE;
          end else if (active != dir_q) begin
            strb_d  = dir_onehot(active);
            dir_d   = active;
            tmr_d   = DELAY_LOAD;
            state_d = ST_DELAY;
          end else if (tmr_q == '0) begin
            strb_d  = dir_onehot(dir_q);
            tmr_d   = PERIOD_LOAD;
            state_d = ST_REPEAT;
          end else begin
            tmr_d = tmr_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      tmr_q   <= '0;
      strb_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      strb_q  <= strb_d;
    end
  end

  assign right = strb_q[DIR_RIGHT[1:0]];
  assign left  = strb_q[DIR_LEFT[1:0]];
  assign up    = strb_q[DIR_UP[1:0]];
  assign down  = strb_q[DIR_DOWN[1:0]];
  assign held  = {stb[DIR_UP[1:0]], stb[DIR_DOWN[1:0]], stb[DIR_LEFT[1:0]], stb[DIR_RIGHT[1:0]]};

endmodule

// File: tb/tb_dir_pad_ctrl.sv
// Directed plus randomized bench for dir_pad_ctrl with a cycle-level
// behavioural model and strobe-timing checks taken from the test plan.
module tb_dir_pad_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic up, down, left, right;
  logic [3:0] held;

  dir_pad_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .held      (held)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int fails = 0;
  int cyc = 0;
  int ev_cyc[$];
  int ev_dir[$];

  // model state, buttons indexed 0=right 1=left 2=up 3=down (priority order)
  logic [3:0] m_s1, m_s2, m_stable, m_strb;
  int m_run[4];
  logic m_busy;
  int m_dir, m_gap, m_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic e_s, input logic r_s);
    int act;
    if (r_s) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_strb = 0; m_busy = 0; m_dir = 4;
      m_gap = 0; m_next = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      return;
    end
    act = 4;
    for (int b = 3; b >= 0; b--) if (m_stable[b]) act = b;
    m_strb = 0;
    if (!e_s || act == 4) begin
      m_busy = 0;
    end else if (!m_busy || act != m_dir) begin
      m_strb[act] = 1'b1; m_dir = act; m_busy = 1; m_gap = 0; m_next = RD + 1;
    end else begin
      m_gap++;
      if (m_gap == m_next) begin
        m_strb[m_dir] = 1'b1; m_gap = 0; m_next = RP + 1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] == m_stable[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] == D) begin m_stable[b] = m_s2[b]; m_run[b] = 0; end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick();
    logic [3:0] raw;
    logic e_s, r_s;
    raw = {btn_down, btn_up, btn_left, btn_right};
    e_s = en;
    r_s = rst;
    @(posedge clk);
    cyc++;
    model_edge(raw, e_s, r_s);
    #1;
    chk("strobes", {28'd0, up, down, left, right}, {28'd0, m_strb[2], m_strb[3], m_strb[1], m_strb[0]});
    chk("held", {28'd0, held}, {28'd0, m_stable[2], m_stable[3], m_stable[1], m_stable[0]});
    chk("onehot", {31'd0, $onehot0({up, down, left, right})}, 32'd1);
    if (right)     begin ev_cyc.push_back(cyc); ev_dir.push_back(0); end
    else if (left) begin ev_cyc.push_back(cyc); ev_dir.push_back(1); end
    else if (up)   begin ev_cyc.push_back(cyc); ev_dir.push_back(2); end
    else if (down) begin ev_cyc.push_back(cyc); ev_dir.push_back(3); end
  endtask

  task automatic chk_ev(input int i, input int base, input int rel, input int dir, input string tag);
    int got_rel, got_dir;
    got_rel = (i < ev_cyc.size()) ? ev_cyc[i] - base : -1;
    got_dir = (i < ev_dir.size()) ? ev_dir[i] : -1;
    chk({tag, "_time"}, got_rel, rel);
    chk({tag, "_dir"}, got_dir, dir);
  endtask

  task automatic clear_ev();
    ev_cyc.delete();
    ev_dir.delete();
  endtask

  initial begin
    int base, base2, k, t, last_chg;
    logic lvl;
    int rel_up[4];
    rel_up = '{7, 18, 22, 26};

    // reset
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_out", {28'd0, up, down, left, right}, 32'd0);
    chk("reset_held", {28'd0, held}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // short glitch on right: rejected
    clear_ev();
    btn_right = 1'b1;
    repeat (3) tick();
    btn_right = 1'b0;
    repeat (12) tick();
    chk("glitch_nstrobe", ev_cyc.size(), 0);
    chk("glitch_held", {28'd0, held}, 32'd0);

    // up held: first strobe and repeats
    clear_ev();
    base = cyc;
    btn_up = 1'b1;
    repeat (30) tick();
    for (int i = 0; i < 4; i++) chk_ev(i, base, rel_up[i], 2, "up_rep");
    chk("up_count", ev_cyc.size(), 5);
    btn_up = 1'b0;
    repeat (2 + D - 1) tick();
    chk("up_rel_held_hi", {31'd0, held[3]}, 32'd1);
    tick();
    chk("up_rel_held_lo", {28'd0, held}, 32'd0);
    clear_ev();
    repeat (15) tick();
    chk("up_rel_quiet", ev_cyc.size(), 0);

    // left+down together, then left released
    clear_ev();
    base = cyc;
    btn_left = 1'b1;
    btn_down = 1'b1;
    repeat (10) tick();
    btn_left = 1'b0;
    repeat (20) tick();
    chk_ev(0, base, 7, 1, "pair_left");
    chk_ev(1, base, 17, 3, "pair_down");
    chk_ev(2, base, 28, 3, "pair_down_rep");
    chk("pair_count", ev_cyc.size(), 3);
    btn_down = 1'b0;
    repeat (12) tick();

    // held with en low, then en raised
    clear_ev();
    en = 1'b0;
    btn_right = 1'b1;
    repeat (15) tick();
    chk("en_low_quiet", ev_cyc.size(), 0);
    chk("en_low_held", {28'd0, held}, 32'd1);
    base = cyc;
    en = 1'b1;
    repeat (3) tick();
    chk_ev(0, base, 1, 0, "en_rise");
    chk("en_rise_count", ev_cyc.size(), 1);
    btn_right = 1'b0;
    repeat (12) tick();

    // reset in the middle of auto-repeat
    clear_ev();
    base = cyc;
    btn_up = 1'b1;
    repeat (20) tick();
    chk_ev(0, base, 7, 2, "prerst_first");
    chk_ev(1, base, 18, 2, "prerst_rep");
    rst = 1'b1;
    tick();
    chk("rst_mid_out", {28'd0, up, down, left, right}, 32'd0);
    chk("rst_mid_held", {28'd0, held}, 32'd0);
    rst = 1'b0;
    clear_ev();
    base2 = cyc;
    repeat (10) tick();
    chk_ev(0, base2, 7, 2, "postrst_first");
    chk("postrst_count", ev_cyc.size(), 1);
    btn_up = 1'b0;
    repeat (12) tick();

    // random bounce on left, then steady high
    clear_ev();
    lvl = 1'b0;
    last_chg = cyc;
    t = 0;
    while (t < 50) begin
      k = $urandom_range(1, 3);
      lvl = ~lvl;
      btn_left = lvl;
      last_chg = cyc;
      repeat (k) tick();
      t += k;
    end
    if (!btn_left) begin
      btn_left = 1'b1;
      last_chg = cyc;
    end
    repeat (12) tick();
    chk_ev(0, last_chg, 7, 1, "bounce_first");
    chk("bounce_count", ev_cyc.size(), 1);
    btn_left = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
    $finish;
  end

endmodule
